// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the exec_sequencer control FSM: state encodings,
// trap-cause codes, reset PC and the instruction step size.
package exec_sequencer_pkg;

    // 3-bit state encodings
    localparam logic [2:0] StateIdle  = 3'd0;
    localparam logic [2:0] StateFetch = 3'd1;
    localparam logic [2:0] StateWait  = 3'd2;
    localparam logic [2:0] StateExec  = 3'd3;
    localparam logic [2:0] StateHalt  = 3'd4;
    localparam logic [2:0] StateTrap  = 3'd5;

    typedef enum logic [2:0] {
        StIdle  = StateIdle,
        StFetch = StateFetch,
        StWait  = StateWait,
        StExec  = StateExec,
        StHalt  = StateHalt,
        StTrap  = StateTrap
    } state_e;

    // Trap-cause codes
    localparam logic [1:0] CauseNone    = 2'd0;
    localparam logic [1:0] CauseIllegal = 2'd1;
    localparam logic [1:0] CauseTimeout = 2'd2;

    localparam logic [63:0] DefaultResetPc = 64'h8000_0000;
    localparam int unsigned InstStep       = 4;

    // HALT and TRAP are sinks left only by reset
    function automatic logic is_terminal(state_e s);
        return (s == StHalt) || (s == StTrap);
    endfunction

endpackage

// File: rtl/exec_sequencer_pc_gen.sv
// Program counter register with next-PC selection: sequential step of 4 or
// a PC-relative jump by the decoded immediate. Arithmetic wraps.
module exec_sequencer_pc_gen
    import exec_sequencer_pkg::*;
#(
    parameter int unsigned         PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DefaultResetPc)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                sel_jump,
    input  logic [PC_WIDTH-1:0] imm,
    output logic [PC_WIDTH-1:0] pc
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;

    // Next-PC mux, held unless an instruction retires with a PC update
    always_comb begin
        pc_d = pc_q;
        if (en) begin
            pc_d = sel_jump ? (pc_q + imm) : (pc_q + PC_WIDTH'(InstStep));
        end
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: fetch, response wait, execute. Owns the
// PC (via pc_gen), the register-file write strobe, halt/trap flags, the
// fetch timeout and the cycle / retired-instruction counters.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int unsigned         PC_WIDTH   = 64,
    parameter int unsigned         INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(DefaultResetPc),
    // Maximum WAIT cycles before a timeout trap; must be >= 1
    parameter int unsigned         TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    output logic [INST_WIDTH-1:0] inst,
    input  logic [4:0]            rd,
    input  logic [PC_WIDTH-1:0]   imm,
    input  logic                  is_jal,
    input  logic                  is_ebreak,
    input  logic                  inst_not_ipl,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  reg_wen,
    output logic                  halted,
    output logic                  trap,
    output logic [1:0]            trap_cause,
    output logic [63:0]           cycle_cnt,
    output logic [63:0]           instret_cnt
);

    // Counter only needs to hold 0..TIMEOUT-1; reaching TIMEOUT traps instead
    localparam int unsigned     TmoW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    state_e                  state_q;
    logic [INST_WIDTH-1:0]   inst_q;
    logic [TmoW-1:0]         tmo_q;
    logic [1:0]              trap_cause_q;
    logic                    halted_q;
    logic                    trap_q;
    logic                    req_valid_q;
    logic [63:0]             cycle_q;
    logic [63:0]             instret_q;
    logic                    exec_retire;
    logic                    exec_advance;

    // Decoder outputs are only meaningful in EXEC; illegal beats ebreak
    always_comb begin
        exec_retire  = 1'b0;
        exec_advance = 1'b0;
        if (state_q == StExec && !inst_not_ipl) begin
            exec_retire  = 1'b1;
            exec_advance = !is_ebreak;
        end
    end

    assign reg_wen = exec_advance && (rd != 5'd0);

    // Control FSM with registered request, flag and cause outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            inst_q       <= '0;
            tmo_q        <= '0;
            trap_cause_q <= CauseNone;
            halted_q     <= 1'b0;
            trap_q       <= 1'b0;
            req_valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q     <= StFetch;
                    req_valid_q <= 1'b1;
                end
                StFetch: begin
                    if (imem_req_ready) begin
                        tmo_q       <= '0;
                        req_valid_q <= 1'b0;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    if (imem_rsp_valid) begin
                        inst_q  <= imem_rsp_data;
                        state_q <= StExec;
                    end else if (tmo_q == TmoLast) begin
                        trap_q       <= 1'b1;
                        trap_cause_q <= CauseTimeout;
                        state_q      <= StTrap;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                StExec: begin
                    if (inst_not_ipl) begin
                        trap_q       <= 1'b1;
                        trap_cause_q <= CauseIllegal;
                        state_q      <= StTrap;
                    end else if (is_ebreak) begin
                        halted_q <= 1'b1;
                        state_q  <= StHalt;
                    end else begin
                        req_valid_q <= 1'b1;
                        state_q     <= StFetch;
                    end
                end
                StHalt, StTrap: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q     <= StIdle;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Performance counters, frozen once the core has stopped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (!is_terminal(state_q)) begin
                cycle_q <= cycle_q + 64'd1;
            end
            if (exec_retire) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    exec_sequencer_pc_gen #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (exec_advance),
        .sel_jump (is_jal),
        .imm      (imm),
        .pc       (pc)
    );

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc;
    assign inst           = inst_q;
    assign halted         = halted_q;
    assign trap           = trap_q;
    assign trap_cause     = trap_cause_q;
    assign cycle_cnt      = cycle_q;
    assign instret_cnt    = instret_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: table of directed instructions,
// hand-written halt/trap/timeout/reset sequences and a randomized stream
// checked against a per-instruction reference model.
module tb_exec_sequencer;

    localparam int          TMO = 4;
    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [63:0] imem_addr, imm, pc;
    logic [31:0] imem_rsp_data, inst;
    logic [4:0]  rd;
    logic        is_jal, is_ebreak, inst_not_ipl;
    logic        reg_wen, halted, trap;
    logic [1:0]  trap_cause;
    logic [63:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    exec_sequencer #(
        .PC_WIDTH   (64),
        .INST_WIDTH (32),
        .RESET_PC   (RPC),
        .TIMEOUT    (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst           (inst),
        .rd             (rd),
        .imm            (imm),
        .is_jal         (is_jal),
        .is_ebreak      (is_ebreak),
        .inst_not_ipl   (inst_not_ipl),
        .pc             (pc),
        .reg_wen        (reg_wen),
        .halted         (halted),
        .trap           (trap),
        .trap_cause     (trap_cause),
        .cycle_cnt      (cycle_cnt),
        .instret_cnt    (instret_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state, advanced once per instruction
    logic [63:0] m_pc, m_instret, m_cyc;

    typedef struct {
        bit          rst;
        int          rdly;
        int          wdly;
        logic        jal;
        logic [4:0]  rdv;
        logic [63:0] immv;
        logic        wen;
        logic [63:0] off;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic junk_decoder();
        {is_jal, is_ebreak, inst_not_ipl} = 3'($urandom);
        rd  = 5'($urandom);
        imm = {$urandom, $urandom};
    endtask

    // Leaves the DUT at the negedge of its first FETCH cycle
    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_pc      = RPC;
        m_instret = 64'd0;
        m_cyc     = 64'd1;
    endtask

    // One instruction from FETCH to the cycle after EXEC. exp_end: 0 run, 1 halt, 2 trap
    task automatic do_instr(input int rdly, input int wdly, input logic [31:0] word,
                            input logic jal, input logic ebrk, input logic nipl,
                            input logic [4:0] rdv, input logic [63:0] immv,
                            input logic exp_wen, input logic [63:0] exp_npc, input int exp_end);
        chk1("fetch_req_valid", imem_req_valid, 1'b1);
        chk("fetch_addr", imem_addr, m_pc);
        chk("fetch_cycle_cnt", cycle_cnt, m_cyc);
        for (int i = 0; i < rdly; i++) begin
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk1("req_hold_valid", imem_req_valid, 1'b1);
            chk("req_hold_addr", imem_addr, m_pc);
        end
        // A response offered in the accept cycle must be ignored
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~word;
        @(negedge clk);
        imem_req_ready = 1'($urandom_range(0, 1));
        for (int i = 0; i < wdly; i++) begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            chk1("wait_req_low", imem_req_valid, 1'b0);
            @(negedge clk);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        @(negedge clk);
        imem_rsp_data = ~word;
        is_jal        = jal;
        is_ebreak     = ebrk;
        inst_not_ipl  = nipl;
        rd            = rdv;
        imm           = immv;
        #1;
        chk1("exec_reg_wen", reg_wen, exp_wen);
        chk("exec_inst", 64'(inst), 64'(word));
        chk("exec_cycle_cnt", cycle_cnt, m_cyc + 64'(rdly + wdly + 2));
        chk("exec_pc", pc, m_pc);
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        junk_decoder();
        #1;
        m_cyc = m_cyc + 64'(rdly + wdly + 3);
        if (exp_end != 2) m_instret = m_instret + 64'd1;
        m_pc = exp_npc;
        chk("post_pc", pc, m_pc);
        chk("post_instret", instret_cnt, m_instret);
        chk("post_cycle_cnt", cycle_cnt, m_cyc);
        chk("post_inst", 64'(inst), 64'(word));
        chk1("post_reg_wen", reg_wen, 1'b0);
        chk1("post_halted", halted, exp_end == 1);
        chk1("post_trap", trap, exp_end == 2);
        chk("post_trap_cause", 64'(trap_cause), (exp_end == 2) ? 64'd1 : 64'd0);
        chk1("post_req_valid", imem_req_valid, exp_end == 0);
    endtask

    // Core must stay stopped whatever the environment does
    task automatic hold_terminal(input int n, input logic exp_halt, input logic [1:0] exp_cause);
        for (int i = 0; i < n; i++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            junk_decoder();
            #1;
            chk1("stop_req_valid", imem_req_valid, 1'b0);
            chk1("stop_reg_wen", reg_wen, 1'b0);
            chk("stop_cycle_cnt", cycle_cnt, m_cyc);
            chk("stop_instret", instret_cnt, m_instret);
            chk("stop_pc", pc, m_pc);
            chk1("stop_halted", halted, exp_halt);
            chk1("stop_trap", trap, !exp_halt);
            chk("stop_cause", 64'(trap_cause), 64'(exp_cause));
            @(negedge clk);
        end
    endtask

    task automatic do_timeout(input int rdly);
        chk1("tmo_fetch_valid", imem_req_valid, 1'b1);
        for (int i = 0; i < rdly; i++) begin
            imem_req_ready = 1'b0;
            @(negedge clk);
            chk1("tmo_fetch_no_trap", trap, 1'b0);
        end
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        imem_req_ready = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            chk1("tmo_wait_no_trap", trap, 1'b0);
            @(negedge clk);
        end
        m_cyc = m_cyc + 64'(rdly + 1 + TMO);
        chk1("tmo_trap", trap, 1'b1);
        chk("tmo_cause", 64'(trap_cause), 64'd2);
        chk1("tmo_halted", halted, 1'b0);
        chk("tmo_cycle_cnt", cycle_cnt, m_cyc);
    endtask

    initial begin
        logic        jal;
        logic [4:0]  rdv;
        logic [63:0] immv;

        rst_n          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        rd             = '0;
        imm            = '0;
        {is_jal, is_ebreak, inst_not_ipl} = 3'b000;

        tbl[0] = '{rst: 0, rdly: 0, wdly: 0, jal: 0, rdv: 5'd1,  immv: 64'h123, wen: 1, off: 64'd4};
        tbl[1] = '{rst: 0, rdly: 0, wdly: 0, jal: 0, rdv: 5'd2,  immv: 64'h456, wen: 1, off: 64'd4};
        tbl[2] = '{rst: 0, rdly: 0, wdly: 0, jal: 0, rdv: 5'd3,  immv: 64'h789, wen: 1, off: 64'd4};
        tbl[3] = '{rst: 1, rdly: 0, wdly: 0, jal: 1, rdv: 5'd1,  immv: 64'h10,  wen: 1, off: 64'h10};
        tbl[4] = '{rst: 0, rdly: 1, wdly: 1, jal: 0, rdv: 5'd0,  immv: 64'h20,  wen: 0, off: 64'd4};
        tbl[5] = '{rst: 0, rdly: 3, wdly: TMO - 1, jal: 0, rdv: 5'd31, immv: 64'h0, wen: 1,
                   off: 64'd4};
        tbl[6] = '{rst: 0, rdly: 0, wdly: 2, jal: 1, rdv: 5'd0,  immv: -64'sd8, wen: 0,
                   off: -64'sd8};
        tbl[7] = '{rst: 0, rdly: 2, wdly: 0, jal: 1, rdv: 5'd9,  immv: 64'h0,  wen: 1, off: 64'h0};

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pc", pc, RPC);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_cause", 64'(trap_cause), 64'd0);
        chk("rst_cycle", cycle_cnt, 64'd0);
        chk("rst_instret", instret_cnt, 64'd0);
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_reg_wen", reg_wen, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_trap", trap, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("idle_req_valid", imem_req_valid, 1'b0);
        @(negedge clk);
        m_pc      = RPC;
        m_instret = 64'd0;
        m_cyc     = 64'd1;

        // Directed table: sequential addi, jal, rd=0, delays, backward jump
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].rst) do_reset();
            do_instr(tbl[i].rdly, tbl[i].wdly, $urandom, tbl[i].jal, 1'b0, 1'b0, tbl[i].rdv,
                     tbl[i].immv, tbl[i].wen, m_pc + tbl[i].off, 0);
            if (i == 2) begin
                chk("seq_pc", pc, 64'h8000_000C);
                chk("seq_instret", instret_cnt, 64'd3);
            end
            if (i == 3) chk("jal_next_addr", imem_addr, 64'h8000_0010);
        end

        // Ebreak halts even when flagged as a jal with a destination
        do_instr(0, 0, 32'h0010_0073, 1'b1, 1'b1, 1'b0, 5'd7, 64'h40, 1'b0, m_pc, 1);
        hold_terminal(20, 1'b1, 2'd0);

        // Unimplemented instruction wins over ebreak and jal
        do_reset();
        do_instr(0, 0, $urandom, 1'b0, 1'b0, 1'b0, 5'd4, 64'h0, 1'b1, m_pc + 64'd4, 0);
        do_instr(1, 0, $urandom, 1'b1, 1'b1, 1'b1, 5'd5, 64'h100, 1'b0, m_pc, 2);
        hold_terminal(5, 1'b0, 2'd1);

        // Ready withheld for 10 cycles is not a timeout; a withheld response is
        do_reset();
        do_instr(10, 0, $urandom, 1'b0, 1'b0, 1'b0, 5'd6, 64'h0, 1'b1, m_pc + 64'd4, 0);
        do_timeout(2);
        hold_terminal(5, 1'b0, 2'd2);

        // Reset during WAIT drops the outstanding response
        do_reset();
        do_instr(0, 0, $urandom, 1'b0, 1'b0, 1'b0, 5'd1, 64'h0, 1'b1, m_pc + 64'd4, 0);
        do_instr(0, 0, $urandom, 1'b1, 1'b0, 1'b0, 5'd1, 64'h30, 1'b1, m_pc + 64'h30, 0);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hdead_beef;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pc", pc, RPC);
        chk("midrst_cycle", cycle_cnt, 64'd0);
        chk("midrst_instret", instret_cnt, 64'd0);
        chk1("midrst_req_valid", imem_req_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_pc      = RPC;
        m_instret = 64'd0;
        m_cyc     = 64'd1;
        do_instr(0, 1, 32'h0000_0513, 1'b0, 1'b0, 1'b0, 5'd10, 64'h0, 1'b1, m_pc + 64'd4, 0);

        // Randomized streams, each ending in a halt or a trap
        for (int b = 0; b < 3; b++) begin
            do_reset();
            for (int k = 0; k < 40; k++) begin
                jal  = ($urandom_range(0, 2) == 0);
                rdv  = 5'($urandom);
                immv = {$urandom, $urandom};
                do_instr($urandom_range(0, 2), $urandom_range(0, TMO - 1), $urandom, jal, 1'b0,
                         1'b0, rdv, immv, rdv != 5'd0, jal ? m_pc + immv : m_pc + 64'd4, 0);
            end
            if (b == 1) begin
                do_instr(0, 0, $urandom, 1'b0, 1'b0, 1'b1, 5'd3, 64'h0, 1'b0, m_pc, 2);
                hold_terminal(3, 1'b0, 2'd1);
            end else begin
                do_instr(1, 1, $urandom, 1'b0, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, m_pc, 1);
                hold_terminal(3, 1'b1, 2'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
